// File: rtl/xsim_mem_burst_reader.sv
// Burst read adapter for the XSim word memory port: splits one burst request into single-word
// read requests (one outstanding at a time) and streams the returned words out through a small FIFO.
module xsim_mem_burst_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 en_rdreq,
  output logic                 rdy_rdreq,
  input  logic [31:0]          rdreq_handle,
  input  logic [31:0]          rdreq_addr,
  input  logic [LEN_WIDTH-1:0] rdreq_len,
  input  logic                 rdy_readrequest,
  output logic                 en_readrequest,
  output logic [31:0]          readrequest_addr,
  output logic [31:0]          readrequest_handle,
  input  logic                 rdy_readresponse,
  output logic                 en_readresponse,
  input  logic [31:0]          readresponse_data,
  output logic                 rddata_valid,
  input  logic                 rddata_ready,
  output logic [31:0]          rddata_data,
  output logic                 rddata_last,
  output logic                 busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic                 active;
  logic                 inflight;
  logic [DATA_W-1:0]    addr_q;
  logic [DATA_W-1:0]    handle_q;
  logic [LEN_WIDTH-1:0] issue_rem;
  logic [LEN_WIDTH-1:0] resp_rem;

  logic [DATA_W-1:0]    fifo_data [FIFO_DEPTH];
  logic                 fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 accept;
  logic                 pop;
  logic                 push;
  logic                 can_push;
  logic                 has_credit;

  // Handshake decode; a response with nothing in flight is stale and dropped so the port never locks.
  always_comb begin
    accept          = en_rdreq & rdy_rdreq;
    pop             = rddata_valid & rddata_ready;
    has_credit      = (count < CNT_W'(FIFO_DEPTH));
    can_push        = has_credit | pop;
    en_readrequest  = (state == S_ISSUE) & rdy_readrequest & ~inflight & has_credit;
    push            = rdy_readresponse & inflight & can_push;
    en_readresponse = active & rdy_readresponse & (~inflight | can_push);
  end

  assign readrequest_addr   = addr_q;
  assign readrequest_handle = handle_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      active    <= 1'b0;
      rdy_rdreq <= 1'b0;
      busy      <= 1'b0;
      inflight  <= 1'b0;
      addr_q    <= '0;
      handle_q  <= '0;
      issue_rem <= '0;
      resp_rem  <= '0;
    end else begin
      active <= 1'b1;
      if (en_readrequest) begin
        inflight <= 1'b1;
      end else if (push) begin
        inflight <= 1'b0;
      end
      if (push) begin
        resp_rem <= resp_rem - LEN_WIDTH'(1);
      end
      case (state)
        S_IDLE: begin
          rdy_rdreq <= ~accept;
          busy      <= accept;
          if (accept) begin
            state     <= S_ISSUE;
            addr_q    <= rdreq_addr;
            handle_q  <= rdreq_handle;
            issue_rem <= rdreq_len;
            resp_rem  <= rdreq_len;
          end
        end
        S_ISSUE: begin
          if (en_readrequest) begin
            addr_q    <= addr_q + DATA_W'(4);
            issue_rem <= issue_rem - LEN_WIDTH'(1);
            if (issue_rem == '0) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Leave only once the final word has landed in the FIFO.
          if (!inflight) begin
            state     <= S_IDLE;
            rdy_rdreq <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          rdy_rdreq <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Response FIFO: registered storage, pop and push may coincide even when full.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= readresponse_data;
        fifo_last[wr_ptr] <= (resp_rem == '0);
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rddata_valid = (count != '0);
  assign rddata_data  = fifo_data[rd_ptr];
  assign rddata_last  = fifo_last[rd_ptr];

  // A request strobe while not ready is dropped by the FSM; flag it in simulation.
  assert property (@(posedge CLK) disable iff (!RST_N) !(en_rdreq && !rdy_rdreq))
    else $error("xsim_mem_burst_reader: en_rdreq while rdy_rdreq=0 ignored");

endmodule
